eth_pkt_fifo: RTL and testbench

Parametrised packet-aware successor to the Ethernet word FIFO, placed between the MAC receive datapath and the host-side reader. Words are written speculatively and only become readable when the writer commits the frame; a bad frame (CRC error, runt) is discarded by rewinding the write pointer. Adds configurable almost-thresholds, sticky overflow/underflow error flags, and an optional first-word-fall-through read port.

---
 rtl/eth_fifo_pkg.sv | 39 +++
 rtl/eth_pkt_fifo_ram.sv | 39 +++
 rtl/eth_pkt_fifo.sv | 126 ++++++++++++
 tb/tb_eth_pkt_fifo.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/eth_fifo_pkg.sv
// Shared constants and helpers for the packet-aware Ethernet FIFO.
// Pointer arithmetic and parameter legality checks live here.
package eth_fifo_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_DEPTH      = 16;

  // Wrap-aware distance between two pointers of width w.
  function automatic logic [31:0] ptr_diff(
    input logic [31:0] a,
    input logic [31:0] b,
    input int          w
  );
    logic [31:0] mask;
    mask = (32'd1 << w) - 32'd1;
    return (a - b) & mask;
  endfunction

  // Depth must be a power of two >= 4, pointers one bit wider.
  function automatic bit params_ok(
    input int depth,
    input int cnt_w
  );
    return (depth >= 4) &&
           ((depth & (depth - 1)) == 0) &&
           (cnt_w == $clog2(depth) + 1);
  endfunction

  // Almost thresholds must sit inside the occupancy range.
  function automatic bit levels_ok(
    input int depth,
    input int afull,
    input int aempty
  );
    return (afull >= 0) && (afull <= depth) &&
           (aempty >= 0) && (aempty <= depth);
  endfunction

endpackage

// File: rtl/eth_pkt_fifo_ram.sv
// Simple dual-port storage for eth_pkt_fifo.
// ETH_PKT_FIFO_FWFT_EN selects async read; otherwise read is registered.
module eth_pkt_fifo_ram
  import eth_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Write port; contents are never reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

`ifdef ETH_PKT_FIFO_FWFT_EN
  assign rdata = mem[raddr];

  logic unused_ok;
  assign unused_ok = rst | re;
`else
  // Registered read port, zeroed on flush so data_out restarts at 0.
  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end
`endif

endmodule

// File: rtl/eth_pkt_fifo.sv
// Packet-aware FIFO: speculative writes, commit/discard, sticky errors.
// Define ETH_PKT_FIFO_FWFT_EN for a first-word fall-through read port.
module eth_pkt_fifo
  import eth_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int CNT_WIDTH  = 5,
  parameter int AFULL_LVL  = DEPTH - 2,
  parameter int AEMPTY_LVL = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  write,
  input  logic                  commit,
  input  logic                  discard,
  input  logic                  read,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  full,
  output logic                  almost_full,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [CNT_WIDTH-1:0]  cnt,
  output logic [CNT_WIDTH-1:0]  wr_cnt,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int AW = CNT_WIDTH - 1;
  localparam logic [CNT_WIDTH-1:0] DEPTH_C  = CNT_WIDTH'(DEPTH);
  localparam logic [CNT_WIDTH-1:0] AFULL_C  = CNT_WIDTH'(AFULL_LVL);
  localparam logic [CNT_WIDTH-1:0] AEMPTY_C = CNT_WIDTH'(AEMPTY_LVL);

  if (!params_ok(DEPTH, CNT_WIDTH)) begin : g_bad_depth
    $error("eth_pkt_fifo: illegal DEPTH/CNT_WIDTH");
  end
  if (!levels_ok(DEPTH, AFULL_LVL, AEMPTY_LVL)) begin : g_bad_lvl
    $error("eth_pkt_fifo: almost level out of range");
  end

  logic [CNT_WIDTH-1:0]  wr_ptr;
  logic [CNT_WIDTH-1:0]  cm_ptr;
  logic [CNT_WIDTH-1:0]  rd_ptr;
  logic [CNT_WIDTH-1:0]  wr_nxt;
  logic                  flush;
  logic                  wr_acc;
  logic                  rd_acc;
  logic [DATA_WIDTH-1:0] ram_rdata;

  assign flush = reset | clear;

  assign cnt    = CNT_WIDTH'(ptr_diff(32'(cm_ptr), 32'(rd_ptr), CNT_WIDTH));
  assign wr_cnt = CNT_WIDTH'(ptr_diff(32'(wr_ptr), 32'(rd_ptr), CNT_WIDTH));

  assign full         = (wr_cnt == DEPTH_C);
  assign almost_full  = (wr_cnt >= AFULL_C);
  assign empty        = (cnt == '0);
  assign almost_empty = (cnt <= AEMPTY_C);

  // A discarded write never lands, so it cannot overflow either.
  assign wr_acc = write & ~full & ~discard;
  assign rd_acc = read & ~empty;
  assign wr_nxt = wr_ptr + CNT_WIDTH'(wr_acc);

  // Pointer update; discard rewinds to the last commit and beats commit.
  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr <= '0;
      cm_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (discard) begin
        wr_ptr <= cm_ptr;
      end else begin
        wr_ptr <= wr_nxt;
        if (commit) cm_ptr <= wr_nxt;
      end
      rd_ptr <= rd_ptr + CNT_WIDTH'(rd_acc);
    end
  end

  // Sticky error flags, cleared only by reset or clear.
  always_ff @(posedge clk) begin
    if (flush) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (write && full && !discard) overflow  <= 1'b1;
      if (read && empty)             underflow <= 1'b1;
    end
  end

  eth_pkt_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (AW)
  ) u_ram (
    .clk   (clk),
    .rst   (flush),
    .we    (wr_acc),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (data_in),
    .re    (rd_acc),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (ram_rdata)
  );

`ifdef ETH_PKT_FIFO_FWFT_EN
  assign data_out   = empty ? '0 : ram_rdata;
  assign data_valid = ~empty;
`else
  logic dv_q;

  // One-cycle valid pulse following each accepted read.
  always_ff @(posedge clk) begin
    if (flush) dv_q <= 1'b0;
    else       dv_q <= rd_acc;
  end

  assign data_out   = ram_rdata;
  assign data_valid = dv_q;
`endif

endmodule

// File: tb/tb_eth_pkt_fifo.sv
// Self-checking bench for eth_pkt_fifo (DEPTH=8).
// Scoreboard queues model committed and pending words.
module tb_eth_pkt_fifo;

  localparam int DW = 32;
  localparam int DEPTH = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          clear = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          write = 1'b0;
  logic          commit = 1'b0;
  logic          discard = 1'b0;
  logic          read = 1'b0;
  logic [DW-1:0] data_out;
  logic          data_valid;
  logic          full;
  logic          almost_full;
  logic          empty;
  logic          almost_empty;
  logic [CW-1:0] cnt;
  logic [CW-1:0] wr_cnt;
  logic          overflow;
  logic          underflow;

  eth_pkt_fifo #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .CNT_WIDTH  (CW),
    .AFULL_LVL  (6),
    .AEMPTY_LVL (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .clear        (clear),
    .data_in      (data_in),
    .write        (write),
    .commit       (commit),
    .discard      (discard),
    .read         (read),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .full         (full),
    .almost_full  (almost_full),
    .empty        (empty),
    .almost_empty (almost_empty),
    .cnt          (cnt),
    .wr_cnt       (wr_cnt),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int nacc = 0;

  logic [DW-1:0] mq[$];
  logic [DW-1:0] pq[$];
  bit            m_of = 1'b0;
  bit            m_uf = 1'b0;
  logic [DW-1:0] last_out = '0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_all(input bit v, input logic [DW-1:0] rv);
    int mc;
    int mw;
    mc = mq.size();
    mw = mc + pq.size();
`ifdef ETH_PKT_FIFO_FWFT_EN
    chk("dvalid", 32'(data_valid), 32'(mc != 0));
    chk("dout", data_out, (mc != 0) ? mq[0] : '0);
`else
    chk("dvalid", 32'(data_valid), 32'(v));
    if (v) last_out = rv;
    chk("dout", data_out, last_out);
`endif
    chk("cnt", 32'(cnt), 32'(mc));
    chk("wr_cnt", 32'(wr_cnt), 32'(mw));
    chk("full", 32'(full), 32'(mw == DEPTH));
    chk("afull", 32'(almost_full), 32'(mw >= 6));
    chk("empty", 32'(empty), 32'(mc == 0));
    chk("aempty", 32'(almost_empty), 32'(mc <= 2));
    chk("ovf", 32'(overflow), 32'(m_of));
    chk("udf", 32'(underflow), 32'(m_uf));
  endtask

  task automatic step(input bit w, input logic [DW-1:0] d, input bit c,
                      input bit x, input bit r, input bit clr);
    int pc;
    int pw;
    bit acc_r;
    logic [DW-1:0] rv;
    write = w;
    data_in = d;
    commit = c;
    discard = x;
    read = r;
    clear = clr;
    pc = mq.size();
    pw = pc + pq.size();
    acc_r = 1'b0;
    rv = '0;
    @(posedge clk);
    if (clr) begin
      mq.delete();
      pq.delete();
      m_of = 1'b0;
      m_uf = 1'b0;
      last_out = '0;
    end else begin
      if (r) begin
        if (pc != 0) begin
          rv = mq.pop_front();
          acc_r = 1'b1;
        end else begin
          m_uf = 1'b1;
        end
      end
      if (w && !x) begin
        if (pw < DEPTH) begin
          pq.push_back(d);
          nacc++;
        end else begin
          m_of = 1'b1;
        end
      end
      if (x) pq.delete();
      else if (c) while (pq.size() > 0) mq.push_back(pq.pop_front());
    end
    #1;
    write = 1'b0;
    commit = 1'b0;
    discard = 1'b0;
    read = 1'b0;
    clear = 1'b0;
    check_all(acc_r, rv);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    mq.delete();
    pq.delete();
    m_of = 1'b0;
    m_uf = 1'b0;
    last_out = '0;
    check_all(1'b0, '0);
  endtask

  initial begin
    do_reset();

    for (int i = 0; i < 3; i++) step(1, 32'hA0 + i, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);

    for (int i = 0; i < 4; i++) step(1, 32'hB0 + i, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);

    step(1, 32'h55, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 8; i++) step(1, 32'hF0 + i, i == 7, 0, 0, 0);
    step(1, 32'hEE, 1, 0, 0, 0);
    step(1, 32'hEF, 1, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 1, 0);
    step(1, 32'hE5, 0, 0, 0, 1);

    nacc = 0;
    for (int k = 0; k < 400 && (nacc < 20 || mq.size() != 0 ||
         pq.size() != 0); k++) begin
      step(nacc < 20 && $urandom_range(0, 3) != 0, 32'hC00 + k,
           $urandom_range(0, 2) == 0 || nacc >= 20, 0,
           $urandom_range(0, 2) != 0, 0);
    end
    chk("stream_done", 32'(nacc == 20 && mq.size() == 0), 32'd1);

    step(1, 32'hD0, 1, 0, 0, 0);
    step(1, 32'hDD, 1, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0);

    step(1, 32'hE0, 1, 0, 0, 0);
    step(1, 32'hE1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    step(1, 32'hE2, 1, 0, 1, 1);
    step(0, 0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
